// File: rtl/led_status_sched.sv
// led_status_sched: round-robin LED pattern scheduler with blink sequencing and idle heartbeat
module led_status_sched #(
   parameter int OscF       = 24_000_000,
   parameter int TickHz     = 4,
   parameter int NumReq     = 4,
   parameter int BlinkCount = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NumReq-1:0]     req_i,
   input  logic [3*NumReq-1:0]   pat_i,
   output logic [2:0]            led_o,
   output logic [NumReq-1:0]     grant_o,
   output logic                  busy_o
);
   localparam int TickDiv = OscF / TickHz;
   localparam int CW      = $clog2(TickDiv);
   localparam int PW      = NumReq > 1 ? $clog2(NumReq) : 1;
   localparam int BW      = $clog2(BlinkCount + 1);
   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q;
   logic                tick;
   logic [NumReq-1:0]   pend_q, pend_d, clr;
   logic [2:0]          patreg_q [NumReq];
   logic [2:0]          hb_q, hb_d, show_q, show_d, led_q, led_d;
   logic [PW-1:0]       last_q, last_d, win, idx;
   logic [BW-1:0]       blink_q, blink_d;
   logic [NumReq-1:0]   grant_q, grant_d;
   logic                busy_q, found;
   assign tick    = cnt_q == CW'(TickDiv - 1);
   assign led_o   = led_q;
   assign grant_o = grant_q;
   assign busy_o  = busy_q;
   // free-running tick divider, independent of the display state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= tick ? '0 : cnt_q + 1'b1;
   end
   // round-robin search for the first pending requester after the last winner
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= NumReq; k++) begin
         idx = PW'((int'(last_q) + k) % NumReq);
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
   // display state machine, request bookkeeping and next LED value
   always_comb begin
      state_d = state_q;
      hb_d    = hb_q;
      last_d  = last_q;
      show_d  = show_q;
      blink_d = blink_q;
      clr     = '0;
      grant_d = '0;
      unique case (state_q)
         IDLE: if (tick) begin
            if (found) begin
               grant_d[win] = 1'b1;
               clr[win]     = 1'b1;
               last_d       = win;
               show_d       = patreg_q[win];
               blink_d      = '0;
               state_d      = ON;
            end else hb_d = hb_q + 3'd1;
         end
         ON:  if (tick) state_d = OFF;
         OFF: if (tick) begin
            if (blink_q == BW'(BlinkCount - 1)) state_d = IDLE;
            else begin
               blink_d = blink_q + 1'b1;
               state_d = ON;
            end
         end
         default: state_d = IDLE;
      endcase
      pend_d = (pend_q & ~clr) | req_i;
      led_d  = state_d == ON ? show_d : state_d == OFF ? 3'b000 : hb_d;
   end
   // state and registered outputs; a same-cycle request overrides the grant clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         hb_q    <= '0;
         last_q  <= PW'(NumReq - 1);
         show_q  <= '0;
         blink_q <= '0;
         led_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         for (int i = 0; i < NumReq; i++) patreg_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         hb_q    <= hb_d;
         last_q  <= last_d;
         show_q  <= show_d;
         blink_q <= blink_d;
         led_q   <= led_d;
         grant_q <= grant_d;
         busy_q  <= state_d != IDLE;
         for (int i = 0; i < NumReq; i++) if (req_i[i]) patreg_q[i] <= pat_i[3*i +: 3];
      end
   end
endmodule
